// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared Y86 instruction codes, status encodings and memory-stage types.
package memory_stage_pkg;
    localparam int WORD_BYTES = 8;
    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;
    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;
    typedef enum logic {RUN, STOPPED} state_e;
endpackage

// File: rtl/data_mem.sv
// data_mem: byte-addressed data memory with one 8-byte little-endian combinational read
// port, one 8-byte synchronous write port and a synchronous clear.
module data_mem #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we_i,
    input  logic [$clog2(MEM_BYTES)-1:0] addr_i,
    input  logic [63:0]                  wdata_i,
    output logic [63:0]                  rdata_o
);
    localparam int AW = $clog2(MEM_BYTES);
    logic [7:0] mem_q [MEM_BYTES];
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else if (we_i) for (int i = 0; i < 8; i++) mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
    end
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < 8; i++) rdata_o[8*i +: 8] = mem_q[addr_i + AW'(i)];
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86 memory-access stage with address/control decode, status generation
// and a RUN/STOPPED machine that freezes status and blocks accesses once stopped.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [2:0]  stat,
    output logic        halted
);
    localparam int AW = $clog2(MEM_BYTES);
    logic        use_a, rd, wr, we;
    logic [63:0] addr, wdata, rdata;
    logic [2:0]  stat_now, stat_q, stat_d;
    state_e      state_q, state_d;

    assign use_a      = icode == IPOPQ || icode == IRET;
    assign rd         = icode == IMRMOVQ || use_a;
    assign wr         = icode == IRMMOVQ || icode == IPUSHQ || icode == ICALL;
    assign addr       = use_a ? valA : valE;
    assign wdata      = icode == ICALL ? valP : valA;
    // Full 64-bit compare so huge addresses cannot alias into the array
    assign dmem_error = (rd || wr) && addr > 64'(MEM_BYTES - WORD_BYTES);
    assign stat_now   = (imem_error || dmem_error) ? SADR :
                        !instr_valid               ? SINS :
                        icode == IHALT             ? SHLT : SAOK;
    assign we         = wr && !dmem_error && !imem_error && instr_valid && !halted && !rst;

    data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .addr_i  (addr[AW-1:0]),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = (state_q == RUN && stat_now != SAOK) ? STOPPED : state_q;
        stat_d  = state_q == RUN ? stat_now : stat_q;
    end

    always_comb begin
        halted = state_q == STOPPED;
        stat   = halted ? stat_q : stat_now;
        valM   = (rd && !dmem_error && !halted) ? rdata : '0;
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against a byte-array model.
module tb_memory_stage;
    localparam int MB = 1024;
    logic        clk = 0, rst = 0, instr_valid = 1, imem_error = 0;
    logic [3:0]  icode = 1;
    logic [63:0] valA = 0, valE = 0, valP = 0, valM;
    logic        dmem_error, halted;
    logic [2:0]  stat;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  m [MB];
    bit          stp = 0;
    logic [2:0]  lst = 1;

    memory_stage #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .icode(icode), .valA(valA), .valE(valE), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .valM(valM), .dmem_error(dmem_error), .stat(stat), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare outputs with the model, then advance the model at the edge
    task automatic cyc(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input bit iv = 1, input bit ie = 0, input bit r = 0);
        logic [63:0] ad, exp_m, wd;
        bit          rd, wr, err;
        logic [2:0]  st;
        icode = ic; valA = a; valE = e; valP = p; instr_valid = iv; imem_error = ie; rst = r;
        #4;
        rd  = ic == 5 || ic == 9 || ic == 11;
        wr  = ic == 4 || ic == 8 || ic == 10;
        ad  = (ic == 9 || ic == 11) ? a : e;
        err = (rd || wr) && ad > 64'(MB - 8);
        st  = (ie || err) ? 3 : !iv ? 4 : ic == 0 ? 2 : 1;
        exp_m = 0;
        if (rd && !err && !stp) for (int k = 0; k < 8; k++) exp_m[8*k +: 8] = m[int'(ad) + k];
        chk("valM", valM, exp_m);
        chk("dmem_error", 64'(dmem_error), 64'(err));
        chk("stat", 64'(stat), 64'(stp ? lst : st));
        chk("halted", 64'(halted), 64'(stp));
        @(posedge clk);
        if (r) begin
            foreach (m[i]) m[i] = 0;
            stp = 0;
            lst = 1;
        end else begin
            wd = ic == 8 ? p : a;
            if (wr && !err && !ie && iv && !stp)
                for (int k = 0; k < 8; k++) m[int'(ad) + k] = wd[8*k +: 8];
            if (!stp && st != 1) begin
                stp = 1;
                lst = st;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 1, 0, 1);
    endtask

    function automatic logic [63:0] pick();
        int s = $urandom_range(0, 9);
        if (s < 7) return 64'($urandom_range(0, 127));
        if (s < 9) return 64'($urandom_range(MB - 12, MB - 1));
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        foreach (m[i]) m[i] = 0;
        cyc(1, 0, 0, 0);
        chk("reset_halted", 64'(halted), 0);
        chk("reset_stat", 64'(stat), 1);
        // rmmovq then mrmovq at 16
        cyc(4, 64'h1122334455667788, 16, 0);
        cyc(5, 0, 16, 0);
        chk("rmmov_mrmov_valM", valM, 64'h1122334455667788);
        chk("byte16", 64'(dut.u_mem.mem_q[16]), 64'h88);
        chk("byte23", 64'(dut.u_mem.mem_q[23]), 64'h11);
        // call then ret
        cyc(8, 0, 24, 64'h40);
        cyc(9, 24, 0, 0);
        chk("ret_valM", valM, 64'h40);
        chk("ret_stat", 64'(stat), 1);
        // boundary addresses
        cyc(5, 0, MB - 8, 0);
        chk("edge_legal", 64'(dmem_error), 0);
        cyc(5, 0, MB - 7, 0);
        chk("edge_err", 64'(dmem_error), 1);
        chk("edge_stat", 64'(stat), 3);
        chk("edge_valM", valM, 0);
        chk("edge_halted", 64'(halted), 1);
        do_reset();
        cyc(5, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        chk("high_addr_err", 64'(dmem_error), 1);
        do_reset();
        // out-of-range store leaves memory untouched
        cyc(4, 64'hDEADBEEF_CAFEF00D, MB - 4, 0);
        chk("oob_halted", 64'(halted), 1);
        chk("oob_byte", 64'(dut.u_mem.mem_q[MB - 4]), 0);
        do_reset();
        // halt, ignored push, reset clears memory
        cyc(4, 64'h77, 64, 0);
        cyc(0, 0, 0, 0);
        chk("hlt_stat", 64'(stat), 2);
        chk("hlt_halted", 64'(halted), 1);
        cyc(10, 64'h55, 128, 0);
        chk("push_ignored", 64'(dut.u_mem.mem_q[128]), 0);
        do_reset();
        cyc(5, 0, 64, 0);
        chk("cleared_valM", valM, 0);
        // status priority
        cyc(1, 0, 0, 0, 0, 1);
        chk("adr_wins", 64'(stat), 3);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        chk("ins_stat", 64'(stat), 4);
        do_reset();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ic = 4'($urandom_range(0, 15));
            if (ic == 0 && $urandom_range(0, 3) != 0) ic = 1;
            cyc(ic, pick(), pick(), {$urandom, $urandom},
                $urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                stp ? $urandom_range(0, 2) == 0 : $urandom_range(0, 59) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_BYTES, 1024, data-memory size in bytes; byte-addressed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 icode  input  4  instruction code from the execute stage.
REQ-005 valA  input  64  operand A; store data or pop/ret address.
REQ-006 valE  input  64  execute-stage result; effective address for most accesses.
REQ-007 valP  input  64  incremented PC; store data for call.
REQ-008 instr_valid  input  1  fetch decoded a legal icode.
REQ-009 imem_error  input  1  fetch address fault.
REQ-010 valM  output  64  data read from memory.
REQ-011 dmem_error  output  1  current access out of range.
REQ-012 stat  output  3  processor status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-013 halted  output  1  sticky stop flag.

Function
REQ-014 The address SHALL be valA for popq (B) and ret (9); it SHALL be valE for rmmovq (4), mrmovq (5), pushq (A) and call (8).
REQ-015 The block SHALL read for mrmovq, popq and ret, and write for rmmovq, pushq and call; all other icodes SHALL perform no access.
REQ-016 Write data SHALL be valP for call and valA for rmmovq and pushq.
REQ-017 All accesses SHALL be 8 bytes, little-endian: byte addr holds bits 7:0 and byte addr+7 holds bits 63:56.
REQ-018 dmem_error SHALL be 1 when an access occurs and addr > MEM_BYTES-8 (unsigned 64-bit compare, no wrap); otherwise 0.
REQ-019 Reads SHALL be combinational, so valM is valid in the same cycle; valM SHALL be 0 when there is no read or dmem_error=1.
REQ-020 A write SHALL commit on the rising clk edge and is visible to reads from the next cycle onward.
REQ-021 A write SHALL be suppressed when dmem_error, imem_error, !instr_valid, halted or rst is true.
REQ-022 stat SHALL be combinational with priority: ADR if imem_error or dmem_error; else INS if !instr_valid; else HLT if icode=0; else AOK.
REQ-023 The FSM SHALL have two states: RUN and STOPPED. It SHALL go from RUN to STOPPED on an edge where stat!=AOK. STOPPED SHALL be left only by rst.
REQ-024 halted SHALL be 1 exactly in STOPPED.
REQ-025 While halted, stat SHALL hold the value latched on entry to STOPPED, and valM SHALL be 0.
REQ-026 An access at addr=MEM_BYTES-8 SHALL be legal; MEM_BYTES-7 SHALL raise dmem_error; addresses with high bits set (e.g. 64'hFFFF_FFFF_FFFF_FFF8) SHALL raise dmem_error.

Reset
REQ-027 On a rising edge with rst=1, the state SHALL become RUN, the latched stat SHALL become AOK, and all memory bytes SHALL be cleared to 0.
REQ-028 rst SHALL take priority over any concurrent write or FSM transition, including mid-operation.
REQ-029 After reset, halted SHALL be 0, valM SHALL be 0, and dmem_error and stat SHALL follow the current inputs.

Structure
REQ-030 The icode constants (IHALT..IPOPQ) and the stat encodings SHALL live in the shared Y86 package used by fetch, decode and execute.
REQ-031 The memory array SHALL be a sub-module named data_mem: MEM_BYTES bytes, one 8-byte combinational read port, one 8-byte synchronous write port, synchronous clear.
REQ-032 The address/control decode and the FSM SHALL reside in memory_stage.

Verification
REQ-033 rmmovq: icode=4, valE=16, valA=64'h1122334455667788; next cycle mrmovq with icode=5, valE=16 -> valM=64'h1122334455667788; a byte-level check SHALL show byte 16 = 8'h88.
REQ-034 call: icode=8, valE=24, valP=64'h40; then ret: icode=9, valA=24 -> valM=64'h40, stat=1.
REQ-035 mrmovq with valE=MEM_BYTES-8 -> dmem_error=0; with valE=MEM_BYTES-7 -> dmem_error=1, stat=3, valM=0; halted=1 after the edge.
REQ-036 rmmovq with valE=MEM_BYTES-4 -> no write occurs, memory is unchanged, and halted is set.
REQ-037 icode=0 -> stat=2 and halted=1 next cycle; a subsequent pushq is ignored; rst=1 for one edge -> halted=0, memory reads 0.
REQ-038 instr_valid=0 and imem_error=1 together -> stat=3 (ADR wins); with only instr_valid=0 -> stat=4.
